// File: rtl/stack_ctrl.sv
//------------------------------------------------------------------------------
// stack_ctrl : operand-stack sequencer driving a single-port synchronous RAM.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module stack_ctrl #(
  parameter int DATA_SIZE  = 11,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_op,
  input  logic [DATA_SIZE-1:0]  req_data,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_SIZE-1:0]  rsp_data,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_SIZE-1:0]  mem_wdata,
  input  logic [DATA_SIZE-1:0]  mem_rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  err,
  input  logic                  clr_err
);

  localparam logic [DEPTH_LOG2:0]   C_DEPTH  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   C_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] C_ONE_A  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                 state_q;
  logic [DEPTH_LOG2:0]    count_q;
  logic                   err_q;
  logic                   err_d;
  logic                   rsp_valid_q;
  logic [DATA_SIZE-1:0]   rsp_data_q;
  logic [DATA_SIZE-1:0]   data_q;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_accept;
  logic                   w_err_set;
  logic [DEPTH_LOG2-1:0]  w_rd_addr;

  assign w_full    = (count_q == C_DEPTH);
  assign w_empty   = (count_q == '0);
  assign w_accept  = req_valid && (state_q == S_IDLE);
  assign w_err_set = w_accept && (req_op ? w_empty : w_full);
  // Error set takes priority over a simultaneous clear.
  assign err_d     = (err_q && !clr_err) || w_err_set;
  assign w_rd_addr = count_q[DEPTH_LOG2-1:0] - C_ONE_A;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      data_q      <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      err_q       <= err_d;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            data_q <= req_data;
            if (!req_op) begin
              if (!w_full) state_q <= S_WRITE;
            end else if (w_empty) begin
              rsp_data_q  <= '0;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= S_READ;
            end
          end
        end
        S_WRITE: begin
          count_q <= count_q + C_ONE;
          state_q <= S_IDLE;
        end
        S_READ: begin
          count_q <= count_q - C_ONE;
          state_q <= S_RESP;
        end
        S_RESP: begin
          rsp_data_q  <= mem_rdata;
          rsp_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE) && rst;
  assign mem_we    = (state_q == S_WRITE) && rst;
  assign mem_addr  = (state_q == S_WRITE) ? count_q[DEPTH_LOG2-1:0] : w_rd_addr;
  assign mem_wdata = data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign count     = count_q;
  assign full      = w_full;
  assign empty     = w_empty;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_stack_ctrl.sv
//------------------------------------------------------------------------------
// tb_stack_ctrl : scoreboard bench for stack_ctrl with a queue-based stack model.
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_stack_ctrl;

  localparam int DW    = 11;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_op = 1'b0;
  logic [DW-1:0] req_data = '0;
  logic          clr_err = 1'b0;
  logic          req_ready, rsp_valid, mem_we, full, empty, err;
  logic [DW-1:0] rsp_data, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [AW:0]   count;

  stack_ctrl #(.DATA_SIZE(DW), .DEPTH_LOG2(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_data(req_data), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .count(count),
    .full(full), .empty(empty), .err(err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM: read data valid one cycle after the address.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  int mstk[$];
  bit m_err = 1'b0;
  int exp_wa[$];
  int exp_wd[$];
  int exp_rd[$];
  int exp_rc[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model: applied at the negedge preceding the accepting edge.
  function automatic void model_accept(bit op, int d, bit clr);
    bit e = 1'b0;
    if (!op) begin
      if (mstk.size() == DEPTH) e = 1'b1;
      else begin
        exp_wa.push_back(mstk.size());
        exp_wd.push_back(d);
        mstk.push_back(d);
      end
    end else begin
      if (mstk.size() == 0) begin
        e = 1'b1;
        exp_rd.push_back(0);
        exp_rc.push_back(cyc + 1);
      end else begin
        exp_rd.push_back(mstk.pop_back());
        exp_rc.push_back(cyc + 3);
      end
    end
    if (e) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endfunction

  // Monitor: memory writes and pop responses against the scoreboard queues.
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_wa.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        chk("write_addr", 32'(mem_addr), exp_wa.pop_front());
        chk("write_data", 32'(mem_wdata), exp_wd.pop_front());
      end
    end
    if (exp_rc.size() > 0 && exp_rc[0] < cyc) begin
      chk("missing_rsp", 0, 1);
      void'(exp_rc.pop_front());
      void'(exp_rd.pop_front());
    end
    if (rsp_valid) begin
      if (exp_rc.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        chk("rsp_data", 32'(rsp_data), exp_rd.pop_front());
        chk("rsp_cycle", cyc, exp_rc.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready && t < 20);
    if (!req_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic check_state(string tag);
    chk({tag, "_count"}, 32'(count), mstk.size());
    chk({tag, "_full"},  32'(full),  32'(mstk.size() == DEPTH));
    chk({tag, "_empty"}, 32'(empty), 32'(mstk.size() == 0));
    chk({tag, "_err"},   32'(err),   32'(m_err));
  endtask

  task automatic do_req(bit op, logic [DW-1:0] d, bit clr);
    int t = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_data = d; clr_err = clr;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0; clr_err = 1'b0;
      return;
    end
    model_accept(op, int'(d), clr);
    @(posedge clk);
    #1 req_valid = 1'b0; clr_err = 1'b0;
    wait_ready();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_we", 32'(mem_we), 0);
    rst = 1'b1;
    #1;
    check_state("reset");
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_data", 32'(rsp_data), 0);
    chk("reset_req_ready", 32'(req_ready), 1);

    // LIFO order
    do_req(1'b0, 11'h00A, 1'b0);
    do_req(1'b0, 11'h7FF, 1'b0);
    check_state("lifo_pushed");
    do_req(1'b1, '0, 1'b0);
    do_req(1'b1, '0, 1'b0);
    check_state("lifo_end");

    // Overflow
    for (int i = 1; i <= 4; i++) do_req(1'b0, 11'(i), 1'b0);
    check_state("ovf_full");
    do_req(1'b0, 11'd5, 1'b0);
    check_state("ovf_reject");
    for (int i = 0; i < 4; i++) do_req(1'b1, '0, 1'b0);
    check_state("ovf_drained");

    // Underflow and clear
    @(negedge clk); clr_err = 1'b1; @(posedge clk); #1 clr_err = 1'b0; m_err = 1'b0;
    @(negedge clk);
    check_state("clr0");
    do_req(1'b1, '0, 1'b0);
    check_state("udf");
    @(negedge clk); clr_err = 1'b1; @(posedge clk); #1 clr_err = 1'b0; m_err = 1'b0;
    @(negedge clk);
    check_state("udf_clr");
    do_req(1'b1, '0, 1'b1);
    check_state("udf_set_wins");

    // Reset mid-operation
    do_req(1'b0, 11'h123, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_mem_we", 32'(mem_we), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    mstk.delete();
    m_err = 1'b0;
    repeat (4) @(negedge clk);
    check_state("midrst");
    do_req(1'b0, 11'h055, 1'b0);
    check_state("midrst_push");

    // Handshake: continuous pop requests
    do_req(1'b0, 11'h211, 1'b0);
    do_req(1'b0, 11'h322, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b1; acc = 0;
    for (int k = 0; k < 9; k++) begin
      chk("hs_ready_pattern", 32'(req_ready), 32'((k % 3) == 0));
      if (req_ready) begin
        model_accept(1'b1, 0, 1'b0);
        acc++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("hs_accepts", acc, 3);
    wait_ready();
    check_state("hs_end");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      bit op, clr;
      logic [DW-1:0] d;
      op  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 7) == 0);
      d   = 11'($urandom_range(0, 2047));
      do_req(op, d, clr);
      if ((i % 10) == 0) check_state("rand");
    end

    repeat (5) @(negedge clk);
    check_state("final");
    chk("pending_rsp", exp_rc.size(), 0);
    chk("pending_write", exp_wa.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stack_ctrl.md
# stack_ctrl

Sequencing controller for the operand stack of the stack-architecture core. It owns the stack pointer register and drives a single-port synchronous stack memory. It accepts one push or pop request at a time over a valid/ready handshake and returns popped data as a one-cycle response pulse. It also reports full/empty/count and holds a sticky error flag for overflow and underflow.

## Interface
- DATA_SIZE, 11: width of stack words.
- DEPTH_LOG2, 4: log2 of stack depth; DEPTH = 2**DEPTH_LOG2 entries.
- One clock; reset is synchronous and active-low.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_op  input  1  0 = push, 1 = pop.
- req_data  input  DATA_SIZE  push operand (ignored for pop).
- req_ready  output  1  controller can accept a request this cycle.
- rsp_valid  output  1  one-cycle pulse: rsp_data holds a pop result.
- rsp_data  output  DATA_SIZE  last pop result; holds until the next pop response.
- mem_addr  output  DEPTH_LOG2  stack memory address.
- mem_we  output  1  memory write enable.
- mem_wdata  output  DATA_SIZE  memory write data.
- mem_rdata  input  DATA_SIZE  memory read data, valid one cycle after the address is presented.
- count  output  DEPTH_LOG2+1  current number of entries (stack pointer).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- err  output  1  sticky overflow/underflow flag.
- clr_err  input  1  clears err.

## Operation
- States: IDLE, WRITE, READ, RESP.
- req_ready = 1 only in IDLE with rst = 1. A request is accepted when req_valid & req_ready; op and data are latched.
- Push in IDLE, not full → WRITE.
  - WRITE drives mem_we = 1, mem_addr = count[DEPTH_LOG2-1:0], mem_wdata = latched data.
  - At the end of WRITE: count ← count+1, state → IDLE.
- Push in IDLE, full → stay in IDLE. No memory write, count unchanged, err ← 1.
- Pop in IDLE, not empty → READ.
  - READ drives mem_addr = count−1, mem_we = 0.
  - At the end of READ: count ← count−1, state → RESP.
  - RESP: rsp_data ← mem_rdata at the end of the cycle, state → IDLE. rsp_valid = 1 for the following cycle only.
- Pop in IDLE, empty → stay in IDLE, err ← 1, rsp_data ← 0, rsp_valid = 1 the next cycle.
- clr_err = 1 clears err on the next edge. If an error occurs in the same cycle, set wins (err stays 1).
- Outside WRITE: mem_we = 0; mem_addr and mem_wdata are don't-care.
- mem_we is forced to 0 in any cycle with rst = 0.
- Arithmetic: count is DEPTH_LOG2+1 bits, so DEPTH is representable. Address = low DEPTH_LOG2 bits. No wrap-around is ever performed; overflow and underflow are blocked and flagged instead.

## Timing
- Reset (rst = 0 at an edge): state = IDLE, count = 0, err = 0, rsp_valid = 0, rsp_data = 0. After reset: full = 0, empty = 1, req_ready = 1.
- Reset mid-operation (in WRITE, READ or RESP): abort immediately.
  - No write is committed; the pending pop response is discarded.
  - All outputs take their reset values on the next cycle.
- Push: accept at cycle 0, write in cycle 1, count updated at cycle 2. req_ready returns to 1 at cycle 2; throughput is 1 push per 2 cycles.
- Pop: accept at cycle 0, address in cycle 1, data captured in cycle 2. rsp_valid = 1 in cycle 3; count is updated from cycle 2. Throughput is 1 pop per 3 cycles.
- Rejected (full push / empty pop): 1-cycle accept, err visible at cycle 1. For an empty pop, rsp_valid = 1 at cycle 1.
- A new request may be accepted in the same cycle that rsp_valid is high.
- full, empty and count are registered-state derived and change only on edges.

## Test plan
Bench parameters: DATA_SIZE = 11, DEPTH_LOG2 = 2 (DEPTH = 4).
- Reset: hold rst = 0 for 2 cycles → count = 0, empty = 1, full = 0, err = 0, rsp_valid = 0, req_ready = 1.
- LIFO order: push 0x00A, then push 0x7FF, then pop, then pop.
  - Expect mem_we pulses at addr 0 then 1.
  - Expect rsp_data = 0x7FF, then 0x00A, each with rsp_valid high exactly 3 cycles after accept.
  - End state: count = 0.
- Overflow: push 1, 2, 3, 4 → full = 1, count = 4. Fifth push 5 → no mem_we, count = 4, err = 1. Then pop → rsp_data = 4.
- Underflow and clear: pop on empty → rsp_valid at cycle 1 with rsp_data = 0, err = 1. Assert clr_err → err = 0. Assert clr_err in the same cycle as another empty pop → err stays 1.
- Reset mid-op: push 0x123. Accept a pop, then drive rst = 0 during READ.
  - Expect no rsp_valid, count = 0, err = 0.
  - A following push 0x055 writes addr 0.
- Handshake: req_valid held high continuously with pops → req_ready low in READ and RESP, so exactly one accept per 3 cycles.
